// File: rtl/spawn_scheduler_if.sv
// rtl/spawn_scheduler_if.sv - request, offer and occupancy bus of spawn_scheduler
interface spawn_scheduler_if #(
  parameter int SLOTS = 4
);
  localparam int SW = $clog2(SLOTS);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             auto_en;
  logic [SLOTS-1:0] despawn;
  logic             spawn_valid;
  logic             spawn_ready;
  logic [SW-1:0]    spawn_slot;
  logic [7:0]       spawn_x;
  logic             spawn_src;
  logic [SLOTS-1:0] active;
  logic             dropped;

  modport master (
    input  rx_data, rx_valid, auto_en, despawn, spawn_ready,
    output spawn_valid, spawn_slot, spawn_x, spawn_src, active, dropped
  );

  modport slave (
    output rx_data, rx_valid, auto_en, despawn, spawn_ready,
    input  spawn_valid, spawn_slot, spawn_x, spawn_src, active, dropped
  );
endinterface

// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - allocates remote/auto spawn requests to free slots with cooldown
module spawn_scheduler #(
  parameter int SLOTS    = 4,
  parameter int COOLDOWN = 16,
  parameter int PERIOD   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  spawn_scheduler_if.master bus
);
  localparam int SW = $clog2(SLOTS);
  localparam int TW = $clog2(PERIOD);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN - 1);
  localparam logic [7:0]    LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {IDLE, OFFER, COOL} state_t;

  state_t           state_q, state_d;
  logic             remote_pending_q, remote_pending_d;
  logic [7:0]       remote_x_q, remote_x_d;
  logic             auto_pending_q, auto_pending_d;
  logic [7:0]       auto_x_q, auto_x_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CW-1:0]    cool_q, cool_d;
  logic [SLOTS-1:0] active_q, active_d;
  logic             spawn_valid_q, spawn_valid_d;
  logic [SW-1:0]    spawn_slot_q, spawn_slot_d;
  logic [7:0]       spawn_x_q, spawn_x_d;
  logic             spawn_src_q, spawn_src_d;
  logic             dropped_q, dropped_d;

  logic             handshake;
  logic             served_remote;
  logic             served_auto;
  logic             auto_tick;
  logic             free_found;
  logic [SW-1:0]    free_slot;

  assign handshake     = (state_q == OFFER) && bus.spawn_ready;
  assign served_remote = handshake && !spawn_src_q;
  assign served_auto   = handshake && spawn_src_q;
  assign auto_tick     = bus.auto_en && (timer_q == TIMER_LAST);

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_slot  = SW'(i);
      end
    end
  end

  // Remote capture: a flag cleared by this cycle's handshake frees room for a new byte.
  always_comb begin
    remote_pending_d = remote_pending_q && !served_remote;
    remote_x_d       = remote_x_q;
    dropped_d        = 1'b0;
    if (bus.rx_valid && (bus.rx_data != 8'h00)) begin
      if (remote_pending_d) begin
        dropped_d = 1'b1;
      end else begin
        remote_pending_d = 1'b1;
        remote_x_d       = bus.rx_data;
      end
    end
  end

  // Auto timer, LFSR position source and coalescing auto request.
  always_comb begin
    lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    auto_pending_d = auto_pending_q && !served_auto;
    auto_x_d       = auto_x_q;
    if (!bus.auto_en) begin
      timer_d = '0;
    end else if (auto_tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    if (auto_tick && !auto_pending_d) begin
      auto_pending_d = 1'b1;
      auto_x_d       = lfsr_q;
    end
  end

  // Slot occupancy: a despawn applied after the handshake set wins on the same slot.
  always_comb begin
    active_d = active_q;
    if (handshake) begin
      active_d[spawn_slot_q] = 1'b1;
    end
    active_d = active_d & ~bus.despawn;
  end

  // IDLE/OFFER/COOL sequencing with registered offer fields.
  always_comb begin
    state_d       = state_q;
    cool_d        = cool_q;
    spawn_valid_d = spawn_valid_q;
    spawn_slot_d  = spawn_slot_q;
    spawn_x_d     = spawn_x_q;
    spawn_src_d   = spawn_src_q;
    case (state_q)
      IDLE: begin
        if ((remote_pending_q || auto_pending_q) && free_found) begin
          state_d       = OFFER;
          spawn_valid_d = 1'b1;
          spawn_slot_d  = free_slot;
          spawn_src_d   = !remote_pending_q;
          spawn_x_d     = remote_pending_q ? remote_x_q : auto_x_q;
        end
      end
      OFFER: begin
        if (bus.spawn_ready) begin
          state_d       = COOL;
          spawn_valid_d = 1'b0;
          cool_d        = COOL_LOAD;
        end
      end
      COOL: begin
        if (cool_q == '0) begin
          state_d = IDLE;
        end else begin
          cool_d = cool_q - CW'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        spawn_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      remote_pending_q <= 1'b0;
      remote_x_q       <= 8'h00;
      auto_pending_q   <= 1'b0;
      auto_x_q         <= 8'h00;
      timer_q          <= '0;
      lfsr_q           <= LFSR_SEED;
      cool_q           <= '0;
      active_q         <= '0;
      spawn_valid_q    <= 1'b0;
      spawn_slot_q     <= '0;
      spawn_x_q        <= 8'h00;
      spawn_src_q      <= 1'b0;
      dropped_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      remote_pending_q <= remote_pending_d;
      remote_x_q       <= remote_x_d;
      auto_pending_q   <= auto_pending_d;
      auto_x_q         <= auto_x_d;
      timer_q          <= timer_d;
      lfsr_q           <= lfsr_d;
      cool_q           <= cool_d;
      active_q         <= active_d;
      spawn_valid_q    <= spawn_valid_d;
      spawn_slot_q     <= spawn_slot_d;
      spawn_x_q        <= spawn_x_d;
      spawn_src_q      <= spawn_src_d;
      dropped_q        <= dropped_d;
    end
  end

  assign bus.spawn_valid = spawn_valid_q;
  assign bus.spawn_slot  = spawn_slot_q;
  assign bus.spawn_x     = spawn_x_q;
  assign bus.spawn_src   = spawn_src_q;
  assign bus.active      = active_q;
  assign bus.dropped     = dropped_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb/tb_spawn_scheduler.sv - randomized and directed checks of spawn_scheduler against a reference model
module tb_spawn_scheduler;
  localparam int SLOTS    = 4;
  localparam int COOLDOWN = 4;
  localparam int PERIOD   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  spawn_scheduler_if #(.SLOTS(SLOTS)) bus ();

  spawn_scheduler #(.SLOTS(SLOTS), .COOLDOWN(COOLDOWN), .PERIOD(PERIOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index, pending requests, occupancy and offer window.
  int         cyc = 0;
  bit         m_rp = 0;
  logic [7:0] m_rx = 0;
  bit         m_ap = 0;
  logic [7:0] m_ax = 0;
  int         m_t = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [3:0] m_act = 0;
  bit         m_offer = 0;
  int         m_slot = 0;
  logic [7:0] m_x = 0;
  bit         m_src = 0;
  int         m_idle_at = 0;
  bit         m_drop = 0;

  task automatic tick();
    bit hs, found;
    bit n_rp, n_ap, n_offer, n_src, n_drop;
    logic [7:0] n_rx, n_ax, n_x, n_lfsr;
    logic [3:0] n_act;
    int n_t, n_slot, n_idle;
    if (rst) begin
      n_rp = 0; n_rx = 0; n_ap = 0; n_ax = 0; n_t = 0; n_lfsr = 8'hA5;
      n_act = 0; n_offer = 0; n_slot = 0; n_x = 0; n_src = 0; n_idle = 0; n_drop = 0;
    end else begin
      hs = m_offer && bus.spawn_ready;
      n_rp = m_rp && !(hs && !m_src);
      n_rx = m_rx;
      n_drop = 0;
      if (bus.rx_valid && bus.rx_data != 8'h00) begin
        if (n_rp) n_drop = 1;
        else begin n_rp = 1; n_rx = bus.rx_data; end
      end
      n_ap = m_ap && !(hs && m_src);
      n_ax = m_ax;
      if (!bus.auto_en) n_t = 0;
      else if (m_t == PERIOD - 1) begin
        n_t = 0;
        if (!n_ap) begin n_ap = 1; n_ax = m_lfsr; end
      end else n_t = m_t + 1;
      n_act = m_act;
      if (hs) n_act[m_slot] = 1'b1;
      n_act = n_act & ~bus.despawn;
      n_offer = m_offer; n_slot = m_slot; n_x = m_x; n_src = m_src; n_idle = m_idle_at;
      if (m_offer) begin
        if (bus.spawn_ready) begin n_offer = 0; n_idle = cyc + 1 + COOLDOWN; end
      end else if (cyc >= m_idle_at && (m_rp || m_ap) && m_act != 4'hF) begin
        found = 0;
        for (int i = 0; i < SLOTS; i++)
          if (!found && !m_act[i]) begin found = 1; n_slot = i; end
        n_offer = 1;
        n_src = !m_rp;
        n_x = m_rp ? m_rx : m_ax;
      end
      n_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
    @(posedge clk);
    #1;
    m_rp = n_rp; m_rx = n_rx; m_ap = n_ap; m_ax = n_ax; m_t = n_t; m_lfsr = n_lfsr;
    m_act = n_act; m_offer = n_offer; m_slot = n_slot; m_x = n_x; m_src = n_src;
    m_idle_at = n_idle; m_drop = n_drop;
    cyc++;
  endtask

  task automatic clear_inputs();
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.auto_en = 1'b0;
    bus.despawn = '0; bus.spawn_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d);
    bus.rx_valid = 1'b1; bus.rx_data = d;
    tick();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vectors++; if (bus.spawn_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.spawn_valid); end
    vectors++; if (bus.spawn_slot !== 2'd0) begin miscompares++; $display("FAIL reset_slot: got %0d want 0", bus.spawn_slot); end
    vectors++; if (bus.spawn_x !== 8'h00) begin miscompares++; $display("FAIL reset_x: got %h want 00", bus.spawn_x); end
    vectors++; if (bus.spawn_src !== 1'b0) begin miscompares++; $display("FAIL reset_src: got %b want 0", bus.spawn_src); end
    vectors++; if (bus.active !== 4'b0000) begin miscompares++; $display("FAIL reset_active: got %b want 0000", bus.active); end
    vectors++; if (bus.dropped !== 1'b0) begin miscompares++; $display("FAIL reset_dropped: got %b want 0", bus.dropped); end
  endtask

  task automatic test_basic_latency();
    int t, seen;
    do_reset();
    bus.spawn_ready = 1'b1;
    send_rx(8'h40);
    vectors++; if (bus.spawn_valid !== 1'b0) begin miscompares++; $display("FAIL basic_t1_valid: got %b want 0", bus.spawn_valid); end
    tick();
    vectors++;
    if (bus.spawn_valid !== 1'b1 || bus.spawn_slot !== 2'd0 || bus.spawn_x !== 8'h40 || bus.spawn_src !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_offer: got v=%b slot=%0d x=%h src=%b want v=1 slot=0 x=40 src=0",
               bus.spawn_valid, bus.spawn_slot, bus.spawn_x, bus.spawn_src);
    end
    tick();
    vectors++; if (bus.active !== 4'b0001) begin miscompares++; $display("FAIL basic_active: got %b want 0001", bus.active); end
    t = cyc - 3;
    send_rx(8'h55);
    seen = -1;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      if (bus.spawn_valid) seen = cyc;
      else tick();
    end
    vectors++; if (seen !== t + 4 + COOLDOWN) begin miscompares++; $display("FAIL basic_spacing: got offer cycle %0d want %0d", seen - t, 4 + COOLDOWN); end
    vectors++; if (bus.spawn_slot !== 2'd1 || bus.spawn_x !== 8'h55) begin miscompares++; $display("FAIL basic_second: got slot=%0d x=%h want slot=1 x=55", bus.spawn_slot, bus.spawn_x); end
    tick();
  endtask

  task automatic test_zero_byte();
    int bad;
    do_reset();
    send_rx(8'h00);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.spawn_valid !== 1'b0 || bus.dropped !== 1'b0) bad++;
      tick();
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL zero_byte: got %0d cycles with valid/dropped set want 0", bad); end
  endtask

  task automatic test_drop();
    int drops, unstable;
    do_reset();
    bus.spawn_ready = 1'b0;
    send_rx(8'h10);
    send_rx(8'h20);
    drops = 0; unstable = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.dropped === 1'b1) drops++;
      if (bus.spawn_valid !== 1'b1 || bus.spawn_x !== 8'h10 || bus.spawn_slot !== 2'd0) unstable++;
      tick();
    end
    vectors++; if (drops != 1) begin miscompares++; $display("FAIL drop_count: got %0d want 1", drops); end
    vectors++; if (unstable != 0) begin miscompares++; $display("FAIL drop_hold: got %0d unstable cycles want 0", unstable); end
    bus.spawn_ready = 1'b1;
    tick();
    bus.spawn_ready = 1'b0;
    vectors++; if (bus.active !== 4'b0001 || bus.spawn_valid !== 1'b0) begin miscompares++; $display("FAIL drop_accept: got active=%b v=%b want 0001 0", bus.active, bus.spawn_valid); end
  endtask

  task automatic test_fill_and_priority();
    int seen, bad;
    do_reset();
    bus.spawn_ready = 1'b1;
    for (int s = 0; s < SLOTS; s++) begin
      send_rx(8'(s + 1));
      seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
        if (bus.spawn_valid) seen = 1;
        tick();
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL fill_timeout: slot %0d got no offer want offer", s); end
    end
    for (int k = 0; k < COOLDOWN + 2; k++) tick();
    vectors++; if (bus.active !== 4'b1111) begin miscompares++; $display("FAIL fill_active: got %b want 1111", bus.active); end
    bus.auto_en = 1'b1;
    send_rx(8'h77);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.spawn_valid !== 1'b0) bad++;
      tick();
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL full_no_offer: got %0d offer cycles want 0", bad); end
    bus.despawn = 4'b0100;
    tick();
    bus.despawn = 4'b0000;
    seen = 0;
    for (int k = 0; k < 2 && !seen; k++) begin
      tick();
      if (bus.spawn_valid) seen = 1;
    end
    vectors++;
    if (!seen || bus.spawn_slot !== 2'd2 || bus.spawn_src !== 1'b0 || bus.spawn_x !== 8'h77) begin
      miscompares++;
      $display("FAIL despawn_reoffer: got v=%b slot=%0d src=%b x=%h want v=1 slot=2 src=0 x=77",
               bus.spawn_valid, bus.spawn_slot, bus.spawn_src, bus.spawn_x);
    end
    tick();
    bus.despawn = 4'b0010;
    tick();
    bus.despawn = 4'b0000;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.spawn_valid) seen = 1;
      else tick();
    end
    vectors++;
    if (!seen || bus.spawn_src !== 1'b1 || bus.spawn_slot !== 2'd1 || bus.spawn_x !== m_ax) begin
      miscompares++;
      $display("FAIL auto_offer: got v=%b src=%b slot=%0d x=%h want v=1 src=1 slot=1 x=%h",
               bus.spawn_valid, bus.spawn_src, bus.spawn_slot, bus.spawn_x, m_ax);
    end
    tick();
    bus.auto_en = 1'b0;
  endtask

  task automatic test_rst_mid_offer();
    int bad;
    do_reset();
    bus.spawn_ready = 1'b1;
    send_rx(8'h11);
    for (int k = 0; k < COOLDOWN + 3; k++) tick();
    bus.spawn_ready = 1'b0;
    send_rx(8'h33);
    tick();
    vectors++; if (bus.spawn_valid !== 1'b1 || bus.active !== 4'b0001) begin miscompares++; $display("FAIL rst_pre: got v=%b active=%b want 1 0001", bus.spawn_valid, bus.active); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (bus.spawn_valid !== 1'b0 || bus.active !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_offer: got v=%b active=%b want 0 0000", bus.spawn_valid, bus.active); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.spawn_valid !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL rst_no_reoffer: got %0d offer cycles want 0", bad); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.rx_valid    = ($urandom_range(0, 5) == 0);
      bus.rx_data     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ((n % 64) == 0) bus.auto_en = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < SLOTS; i++) bus.despawn[i] = ($urandom_range(0, 11) == 0);
      bus.spawn_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 799) == 0);
      tick();
      vectors++;
      if (bus.spawn_valid !== m_offer || bus.spawn_slot !== 2'(m_slot) || bus.spawn_x !== m_x ||
          bus.spawn_src !== m_src || bus.active !== m_act || bus.dropped !== m_drop) begin
        miscompares++;
        $display("FAIL random cycle %0d: got v=%b slot=%0d x=%h src=%b act=%b drop=%b want v=%b slot=%0d x=%h src=%b act=%b drop=%b",
                 n, bus.spawn_valid, bus.spawn_slot, bus.spawn_x, bus.spawn_src, bus.active, bus.dropped,
                 m_offer, m_slot, m_x, m_src, m_act, m_drop);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic_latency();
    test_zero_byte();
    test_drop();
    test_fill_and_priority();
    test_rst_mid_offer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spawn_scheduler.md
# spawn_scheduler

Sequences object spawns for the game-logic layer. It collects spawn requests from two sources: received UART command bytes and an internal periodic auto-spawn timer. It allocates each request to a free object slot and hands it to the object/drawing stage over a valid/ready handshake. A cooldown is enforced between consecutive spawns, and slot occupancy is tracked until the object stage reports a despawn.

## Interface
Parameters:
- SLOTS, 4, number of object slots (2..8)
- COOLDOWN, 16, minimum cycles between an accepted spawn and the next offer (>=1)
- PERIOD, 1024, auto-spawn interval in clk cycles (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received command byte; 0 means no object, and nonzero is the spawn x position
- rx_valid  in  1  single-cycle strobe qualifying rx_data
- auto_en  in  1  enables the auto-spawn timer
- despawn  in  SLOTS  per-slot single-cycle pulse; frees that slot
- spawn_valid  out  1  spawn command offered
- spawn_ready  in  1  object stage accepts the command
- spawn_slot  out  $clog2(SLOTS)  slot index of the offered command
- spawn_x  out  8  x position of the offered command
- spawn_src  out  1  0 = remote (UART), 1 = auto
- active  out  SLOTS  slot occupancy
- dropped  out  1  single-cycle pulse when a remote request is discarded

## Operation
Request capture:
- rx_valid with rx_data != 0 sets remote_pending and latches the byte into remote_x.
- rx_valid with rx_data == 0 is ignored.
- rx_valid with rx_data != 0 while remote_pending is already set: the new byte is discarded, remote_x is unchanged, and dropped pulses for 1 cycle.

Auto timer and position source:
- The auto timer counts 0..PERIOD-1 while auto_en=1.
- When the count is at PERIOD-1 it wraps to 0 and sets auto_pending, latching the current LFSR value into auto_x.
- If auto_pending is already set, the tick coalesces: auto_x is not updated and nothing is dropped.
- auto_en=0 holds the timer at 0. Any existing auto_pending is kept.
- The LFSR is 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It is seeded 8'hA5 on reset and advances every cycle, so it is never 0.

State machine IDLE / OFFER / COOL:
- IDLE: if (remote_pending or auto_pending) and any active bit is 0, go to OFFER.
  - Remote has priority over auto.
  - The slot is the lowest-index free slot.
  - spawn_slot, spawn_x and spawn_src are registered on this transition.
  - If no slot is free, stay in IDLE and keep all requests pending.
- OFFER: spawn_valid=1, and spawn_slot, spawn_x and spawn_src are held stable.
  - On spawn_ready=1: set active[spawn_slot], clear the served pending flag, load the cooldown counter with COOLDOWN-1, and go to COOL.
  - Without ready: stay in OFFER with no timeout. A newer request never replaces the offer.
- COOL: the counter decrements each cycle; at 0 go to IDLE.
  - spawn_valid=0.
  - Capture and despawn continue in this state.

Despawn and simultaneous events:
- despawn[i] clears active[i] on the next edge; a despawn of a free slot has no effect.
- If the handshake and a despawn land in the same cycle, both apply. A despawn of the slot being set wins, leaving active=0.
- rx_valid in the same cycle as the handshake that clears remote_pending is captured as a new request, not dropped.

## Timing
Reset values:
- spawn_valid=0, spawn_slot=0, spawn_x=0, spawn_src=0, active=0, dropped=0
- state=IDLE, pending flags=0, timer=0, LFSR=8'hA5

Latency:
- rx_valid at cycle t sets the pending flag at t+1.
- spawn_valid rises at t+2 (IDLE evaluates at t+1).
- With ready at t+2, active is set at t+3, COOL runs t+3..t+2+COOLDOWN, and IDLE is reached at t+3+COOLDOWN.
- Minimum spacing between accepted spawns is COOLDOWN+2 cycles.
- dropped is registered and asserts the cycle after the offending rx_valid.
- All outputs are registered.
- rst mid-offer drops spawn_valid the next cycle and clears all slots and pending requests.

## Test plan
- Reset, then rx_data=8'h40 with rx_valid at t -> spawn_valid at t+2 with slot 0, x=8'h40, src=0. Ready held high -> active=4'b0001 at t+3, next offer no earlier than t+3+COOLDOWN.
- rx_data=8'h00 with rx_valid -> no pending, spawn_valid stays 0, dropped stays 0.
- Two nonzero bytes 8'h10 and 8'h20 sent 1 cycle apart with ready low -> dropped pulses once, and the offer shows x=8'h10 stably for 20 cycles until ready.
- auto_en=1, PERIOD=8 -> auto offer with src=1 and x equal to the LFSR sample. A remote byte pending at the same time is served first.
- Fill all 4 slots, then send a request -> no offer. despawn[2] pulses -> offer with slot=2 within 2 cycles.
- Assert rst while spawn_valid=1 -> next cycle spawn_valid=0, active=0, and the earlier request is not re-offered.
